// File: rtl/enemy_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | enemy_ctrl_pkg : shared types and constants for enemy_control      |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
package enemy_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_INIT     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_GEN      = 3'd3,
        ST_APPLY    = 3'd4,
        ST_DRAW     = 3'd5,
        ST_DRAW_END = 3'd6
    } enemy_ctrl_state_t;

    localparam logic [7:0] c_overrun_max = 8'd255;

endpackage
`default_nettype wire

// File: rtl/enemy_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | enemy_control_if : phase strobes and handshake to the enemies block|
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
interface enemy_control_if;

    logic       start;
    logic       draw_done;
    logic       init;
    logic       idle;
    logic       gen_move;
    logic       apply_move;
    logic       draw;
    logic [7:0] overrun_count;
    logic       draw_timeout;

    modport master (
        input  start, draw_done,
        output init, idle, gen_move, apply_move, draw, overrun_count, draw_timeout
    );

    modport slave (
        output start, draw_done,
        input  init, idle, gen_move, apply_move, draw, overrun_count, draw_timeout
    );

endinterface
`default_nettype wire

// File: rtl/enemy_control_frame_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | frame_timer : free-running frame down-counter, 1-cycle tick at 0   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module frame_timer #(
    parameter int FRAME_CYCLES = 833333
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic run,
    input  wire logic clear,
    output logic      tick
);

    localparam int              CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = c_reload;
        end else if (run) begin
            count_d = (count_q == '0) ? c_reload : count_q - 1'b1;
        end
    end

    assign tick = run && !clear && (count_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= c_reload;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/enemy_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | enemy_control : phase sequencer for the enemies block, frame-paced |
// |                 with overrun counting. Optional draw watchdog is   |
// |                 enabled by defining ENEMY_CTRL_WATCHDOG_EN.        |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module enemy_control
    import enemy_ctrl_pkg::*;
#(
    parameter int FRAME_CYCLES   = 833333,
    parameter int MOVE_DIV       = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic       clock,
    input  wire logic       reset,
    enemy_control_if.master bus
);

    localparam int               DIV_W      = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(MOVE_DIV - 1);

    enemy_ctrl_state_t state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              pending_q, pending_d;
    logic [7:0]        overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              tick;
    logic              wd_fire;

    frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .clock (clock),
        .reset (reset),
        .run   (state_q != ST_OFF),
        .clear (bus.start),
        .tick  (tick)
    );

`ifdef ENEMY_CTRL_WATCHDOG_EN
    localparam logic [15:0] c_wd_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_q, wd_d;

    // Counter sits at zero outside DRAW, so every DRAW entry starts from 0.
    always_comb begin
        wd_d = '0;
        if (state_q == ST_DRAW) begin
            wd_d = wd_q + 16'd1;
        end
    end

    assign wd_fire = (wd_q == c_wd_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_fire            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        timeout_d = 1'b0;

        if (tick && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
            if (overrun_q != c_overrun_max) begin
                overrun_d = overrun_q + 8'd1;
            end
        end

        case (state_q)
            ST_OFF:      state_d = ST_OFF;
            ST_INIT:     state_d = ST_IDLE;
            ST_IDLE: begin
                if (tick || pending_q) begin
                    pending_d = 1'b0;
                    div_d     = (div_q == c_div_last) ? '0 : div_q + 1'b1;
                    state_d   = (div_q == '0) ? ST_GEN : ST_DRAW;
                end
            end
            ST_GEN:      state_d = ST_APPLY;
            ST_APPLY:    state_d = ST_DRAW;
            ST_DRAW: begin
                if (bus.draw_done) begin
                    state_d = ST_DRAW_END;
                end else if (wd_fire) begin
                    state_d   = ST_DRAW_END;
                    timeout_d = 1'b1;
                end
            end
            ST_DRAW_END: state_d = ST_IDLE;
            default:     state_d = ST_OFF;
        endcase

        if (bus.start) begin
            state_d   = ST_INIT;
            div_d     = '0;
            pending_d = 1'b0;
            overrun_d = '0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_OFF;
            div_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.init          = (state_q == ST_INIT);
    assign bus.idle          = (state_q == ST_IDLE);
    assign bus.gen_move      = (state_q == ST_GEN);
    assign bus.apply_move    = (state_q == ST_APPLY);
    assign bus.draw          = (state_q == ST_DRAW);
    assign bus.overrun_count = overrun_q;
    assign bus.draw_timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_control.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_enemy_control : directed bench, two instances (MOVE_DIV 1 and 4)|
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_enemy_control;

    localparam logic [4:0] c_s_off   = 5'b00000;
    localparam logic [4:0] c_s_init  = 5'b10000;
    localparam logic [4:0] c_s_idle  = 5'b01000;
    localparam logic [4:0] c_s_gen   = 5'b00100;
    localparam logic [4:0] c_s_apply = 5'b00010;
    localparam logic [4:0] c_s_draw  = 5'b00001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    enemy_control_if ia ();
    enemy_control_if ib ();

    enemy_control #(
        .FRAME_CYCLES   (16),
        .MOVE_DIV       (1),
        .TIMEOUT_CYCLES (8)
    ) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ia.master)
    );

    enemy_control #(
        .FRAME_CYCLES   (16),
        .MOVE_DIV       (4),
        .TIMEOUT_CYCLES (1000)
    ) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ib.master)
    );

    logic [4:0] str_a;
    logic [4:0] str_b;
    assign str_a = {ia.init, ia.idle, ia.gen_move, ia.apply_move, ia.draw};
    assign str_b = {ib.init, ib.idle, ib.gen_move, ib.apply_move, ib.draw};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Steady run after start: frame f begins at c = 16 + 16*f.
    function automatic logic [4:0] exp_run(input int c, input bit move_frame);
        int p;
        if (c == 0)  return c_s_init;
        if (c < 16)  return c_s_idle;
        p = (c - 16) % 16;
        if (move_frame) begin
            case (p)
                0:       return c_s_gen;
                1:       return c_s_apply;
                2, 3:    return c_s_draw;
                4:       return c_s_off;
                default: return c_s_idle;
            endcase
        end
        case (p)
            0, 1:    return c_s_draw;
            2:       return c_s_off;
            default: return c_s_idle;
        endcase
    endfunction

    function automatic logic [4:0] exp_overrun_b(input int c);
        if (c == 0)                return c_s_init;
        if (c < 16)                return c_s_idle;
        if (c == 16)               return c_s_gen;
        if (c == 17)               return c_s_apply;
        if (c <= 57)               return c_s_draw;
        if (c == 58 || c == 61)    return c_s_off;
        if (c == 60)               return c_s_draw;
        if (c == 59 || c <= 63)    return c_s_idle;
        if (c <= 66)               return c_s_draw;
        if (c == 67)               return c_s_init;
        if (c <= 82)               return c_s_idle;
        if (c == 83)               return c_s_gen;
        return c_s_apply;
    endfunction

    function automatic logic [4:0] exp_wd_a(input int c);
        if (c == 0)  return c_s_init;
        if (c < 16)  return c_s_idle;
        if (c == 16) return c_s_gen;
        if (c == 17) return c_s_apply;
`ifdef ENEMY_CTRL_WATCHDOG_EN
        if (c <= 25) return c_s_draw;
        if (c == 26) return c_s_off;
        return c_s_idle;
`else
        return c_s_draw;
`endif
    endfunction

    initial begin
        logic [4:0] ea;
        logic [4:0] eb;
        bit         mv_b;
        int         ov;
        logic       to;

        ia.start = 1'b0; ia.draw_done = 1'b0;
        ib.start = 1'b0; ib.draw_done = 1'b0;
        repeat (3) cyc();
        check("rst_a_strobes", 32'(str_a), 32'(c_s_off));
        check("rst_b_strobes", 32'(str_b), 32'(c_s_off));
        check("rst_a_overrun", 32'(ia.overrun_count), 32'd0);
        check("rst_a_timeout", 32'(ia.draw_timeout), 32'd0);
        check("rst_b_timeout", 32'(ib.draw_timeout), 32'd0);
        reset = 1'b0;
        repeat (6) cyc();
        check("off_without_start", 32'(str_a), 32'(c_s_off));

        // Frames on both instances: every frame moves on A, every 4th on B.
        ia.start = 1'b1; ib.start = 1'b1;
        cyc();
        ia.start = 1'b0; ib.start = 1'b0;
        for (int c = 0; c <= 144; c++) begin
            mv_b = (c < 16) || ((((c - 16) / 16) % 4) == 0);
            ea   = exp_run(c, 1'b1);
            eb   = exp_run(c, mv_b);
            check($sformatf("run_a c=%0d", c), 32'(str_a), 32'(ea));
            check($sformatf("run_b c=%0d", c), 32'(str_b), 32'(eb));
            ia.draw_done = (c >= 16) && (((c - 16) % 16) == 3);
            ib.draw_done = (c >= 16) && (((c - 16) % 16) == (mv_b ? 3 : 1));
            if (c < 144) cyc();
        end
        check("run_a_overrun", 32'(ia.overrun_count), 32'd0);
        check("run_b_overrun", 32'(ib.overrun_count), 32'd0);
        ia.draw_done = 1'b0; ib.draw_done = 1'b0;

        // B: long draw causes two overruns, then restart mid-DRAW with draw_done.
        ib.start = 1'b1;
        cyc();
        ib.start = 1'b0;
        for (int c = 0; c <= 84; c++) begin
            ov = (c < 32) ? 0 : (c < 48) ? 1 : (c < 67) ? 2 : 0;
            check($sformatf("ovr_b c=%0d", c), 32'(str_b), 32'(exp_overrun_b(c)));
            check($sformatf("ovr_b_count c=%0d", c), 32'(ib.overrun_count), 32'(ov));
            check($sformatf("ovr_b_timeout c=%0d", c), 32'(ib.draw_timeout), 32'd0);
            ib.draw_done = (c == 57) || (c == 60) || (c == 66);
            ib.start     = (c == 66);
            cyc();
        end
        ib.start = 1'b0; ib.draw_done = 1'b0;

        // A: draw_done never returned.
        ia.start = 1'b1;
        cyc();
        ia.start = 1'b0;
        for (int c = 0; c <= 28; c++) begin
`ifdef ENEMY_CTRL_WATCHDOG_EN
            to = (c == 26);
`else
            to = 1'b0;
`endif
            check($sformatf("wd_a c=%0d", c), 32'(str_a), 32'(exp_wd_a(c)));
            check($sformatf("wd_a_timeout c=%0d", c), 32'(ia.draw_timeout), 32'(to));
            cyc();
        end

        // Reset during GEN, then OFF holds until start.
        ia.start = 1'b1;
        cyc();
        ia.start = 1'b0;
        repeat (16) cyc();
        check("pre_rst_gen", 32'(str_a), 32'(c_s_gen));
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_gen_a_strobes", 32'(str_a), 32'(c_s_off));
        check("rst_gen_b_strobes", 32'(str_b), 32'(c_s_off));
        check("rst_gen_a_overrun", 32'(ia.overrun_count), 32'd0);
        check("rst_gen_a_timeout", 32'(ia.draw_timeout), 32'd0);
        for (int c = 0; c < 20; c++) begin
            cyc();
            check($sformatf("off_hold c=%0d", c), 32'(str_a), 32'(c_s_off));
        end
        ia.start = 1'b1;
        cyc();
        ia.start = 1'b0;
        check("restart_init", 32'(str_a), 32'(c_s_init));
        cyc();
        check("restart_idle", 32'(str_a), 32'(c_s_idle));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
